// File: rtl/apb_master_fsm.sv
// apb_master_fsm: APB3 requester. It accepts one command at a time on a valid/ready stream,
// runs it as a SETUP/ACCESS transfer, and returns the result on a valid/ready response stream.
// PREADY wait states are honoured. A stalled transfer is aborted after TIMEOUT consecutive
// PREADY-low ACCESS cycles. TIMEOUT = 0 disables the abort.
//
// Ports:
//   PCLK, PRESETn                   clock; asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (cmd_ready is high only in IDLE)
//   cmd_write/cmd_addr/cmd_wdata    command fields; cmd_wdata is ignored for reads
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata/rsp_err/rsp_timeout   response fields
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB requester outputs (registered)
//   PRDATA/PREADY/PSLVERR           APB completer inputs
module apb_master_fsm #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e              r_state, w_state_nxt;
  logic                r_psel, w_psel_nxt;
  logic                r_penable, w_penable_nxt;
  logic                r_pwrite, w_pwrite_nxt;
  logic [ADDR_W-1:0]   r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0]   r_pwdata, w_pwdata_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;
  logic                r_rsp_timeout, w_rsp_timeout_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_timeout_hit;

  // Saturating increment: the wait counter must never wrap back below the limit.
  assign w_cnt_inc     = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  // Evaluated on the PREADY-low path only, so PREADY=1 on the limit cycle completes normally.
  assign w_timeout_hit = (TIMEOUT != 0) && (w_cnt_inc == CNT_LIM);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= StIdle;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_psel        <= w_psel_nxt;
      r_penable     <= w_penable_nxt;
      r_pwrite      <= w_pwrite_nxt;
      r_paddr       <= w_paddr_nxt;
      r_pwdata      <= w_pwdata_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_psel_nxt        = r_psel;
    w_penable_nxt     = r_penable;
    w_pwrite_nxt      = r_pwrite;
    w_paddr_nxt       = r_paddr;
    w_pwdata_nxt      = r_pwdata;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_cnt_nxt         = r_cnt;
    unique case (r_state)
      StIdle: begin
        // cmd_ready is implied here, so cmd_valid alone completes the handshake.
        if (cmd_valid) begin
          w_state_nxt   = StSetup;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_pwrite_nxt  = cmd_write;
          w_paddr_nxt   = cmd_addr;
          w_pwdata_nxt  = cmd_write ? cmd_wdata : '0;
        end
      end
      StSetup: begin
        w_state_nxt   = StAccess;
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
      end
      StAccess: begin
        if (PREADY) begin
          w_state_nxt       = StResp;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_rsp_rdata_nxt   = r_pwrite ? '0 : PRDATA;
          w_rsp_err_nxt     = PSLVERR;
          w_rsp_timeout_nxt = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_timeout_hit) begin
            w_state_nxt       = StResp;
            w_psel_nxt        = 1'b0;
            w_penable_nxt     = 1'b0;
            w_rsp_valid_nxt   = 1'b1;
            w_rsp_rdata_nxt   = '0;
            w_rsp_err_nxt     = 1'b1;
            w_rsp_timeout_nxt = 1'b1;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_nxt     = StIdle;
          w_rsp_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign cmd_ready   = (r_state == StIdle);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Bench for apb_master_fsm: a behavioural APB completer with a small memory, plus a
// transaction-level reference model that predicts each response and its cycle of arrival.
module tb_apb_master_fsm;

  localparam int TO_CFG = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] mdl_mem[16];  // reference model's view of memory
  logic [31:0] cmp_mem[16];  // completer's memory, written only by observed APB writes

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;   // PREADY-low ACCESS cycles before PREADY=1
    logic        serr;
    int          stall;   // rsp_ready-low cycles in RESP
  } cmd_t;

  apb_master_fsm #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO_CFG)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int waits, input logic serr, input int stall);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata; c.waits = waits; c.serr = serr; c.stall = stall;
    return c;
  endfunction

  // Called just after a rising edge with the block idle (or about to be); returns just after
  // the response handshake edge. When has_nxt is set, nx is presented during RESP.
  task automatic run_xfer(input cmd_t c, input bit has_nxt, input cmd_t nx);
    bit          to;
    int          n_acc;
    int          idx;
    logic [31:0] exp_rd;
    logic        exp_err;
    idx     = int'(c.addr[5:2]);
    to      = (TO_CFG != 0) && (c.waits >= TO_CFG);
    n_acc   = to ? TO_CFG : c.waits + 1;
    exp_rd  = (!c.wr && !to) ? mdl_mem[idx] : 32'h0;
    exp_err = to || c.serr;
    if (c.wr && !to && !c.serr) mdl_mem[idx] = c.wdata;

    cmd_valid = 1'b1; cmd_write = c.wr; cmd_addr = c.addr; cmd_wdata = c.wdata;
    rsp_ready = 1'b0;
    @(negedge PCLK);
    check_eq("idle_cmd_ready", 64'(cmd_ready), 64'(1));
    check_eq("idle_rsp_valid", 64'(rsp_valid), 64'(0));
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    @(negedge PCLK);
    check_eq("setup_psel_pen", 64'({PSEL, PENABLE}), 64'(2'b10));
    check_eq("setup_paddr", 64'(PADDR), 64'(c.addr));
    check_eq("setup_pwrite", 64'(PWRITE), 64'(c.wr));
    check_eq("setup_pwdata", 64'(PWDATA), 64'(c.wr ? c.wdata : 32'h0));
    check_eq("setup_cmd_ready", 64'(cmd_ready), 64'(0));

    for (int k = 0; k < n_acc; k++) begin
      @(posedge PCLK); #1;
      PREADY  = (k == c.waits);
      PSLVERR = PREADY ? c.serr : 1'($urandom);
      PRDATA  = (PREADY && !c.wr) ? cmp_mem[PADDR[5:2]] : $urandom;
      @(negedge PCLK);
      check_eq("access_psel_pen", 64'({PSEL, PENABLE}), 64'(2'b11));
      check_eq("access_paddr", 64'(PADDR), 64'(c.addr));
      check_eq("access_pwdata", 64'(PWDATA), 64'(c.wr ? c.wdata : 32'h0));
      check_eq("access_rsp_valid", 64'(rsp_valid), 64'(0));
      if (PREADY && PWRITE && !PSLVERR) cmp_mem[PADDR[5:2]] = PWDATA;
    end

    @(posedge PCLK); #1;
    PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
    if (has_nxt) begin
      cmd_valid = 1'b1; cmd_write = nx.wr; cmd_addr = nx.addr; cmd_wdata = nx.wdata;
    end
    for (int s = 0; s <= c.stall; s++) begin
      rsp_ready = (s == c.stall);
      @(negedge PCLK);
      check_eq("resp_valid", 64'(rsp_valid), 64'(1));
      check_eq("resp_rdata", 64'(rsp_rdata), 64'(exp_rd));
      check_eq("resp_err", 64'(rsp_err), 64'(exp_err));
      check_eq("resp_timeout", 64'(rsp_timeout), 64'(to));
      check_eq("resp_bus_idle", 64'({PSEL, PENABLE}), 64'(2'b00));
      check_eq("resp_cmd_ready", 64'(cmd_ready), 64'(0));
      @(posedge PCLK); #1;
    end
    rsp_ready = 1'b0;
    if (!has_nxt) cmd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t c0, c1;
    cmd_t rq[$];
    for (int i = 0; i < 16; i++) begin
      mdl_mem[i] = 32'h0;
      cmp_mem[i] = 32'h0;
    end
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

    @(negedge PCLK);
    check_eq("rst_bus", 64'({PSEL, PENABLE, PWRITE}), 64'(0));
    check_eq("rst_paddr", 64'(PADDR), 64'(0));
    check_eq("rst_pwdata", 64'(PWDATA), 64'(0));
    check_eq("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'(0));
    check_eq("rst_rdata", 64'(rsp_rdata), 64'(0));
    check_eq("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // Zero-wait write, waited read, slave error.
    run_xfer(mk(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 0), 1'b0, c0);
    check_eq("mem_0x10", 64'(cmp_mem[4]), 64'(32'hDEADBEEF));
    run_xfer(mk(1'b0, 32'h10, 32'h0, 3, 1'b0, 0), 1'b0, c0);
    run_xfer(mk(1'b0, 32'h10, 32'h0, 0, 1'b1, 0), 1'b0, c0);
    // Timeouts (read and write), then PREADY on the limit cycle completes normally.
    run_xfer(mk(1'b0, 32'h10, 32'h0, 9, 1'b0, 1), 1'b0, c0);
    run_xfer(mk(1'b1, 32'h10, 32'h11111111, 4, 1'b0, 0), 1'b0, c0);
    run_xfer(mk(1'b0, 32'h10, 32'h0, 3, 1'b0, 0), 1'b0, c0);
    // Back-pressure with a queued command waiting behind the response.
    c0 = mk(1'b1, 32'h14, 32'hCAFEF00D, 1, 1'b0, 5);
    c1 = mk(1'b0, 32'h14, 32'h0, 0, 1'b0, 0);
    run_xfer(c0, 1'b1, c1);
    run_xfer(c1, 1'b0, c0);

    // Reset during ACCESS wait states.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h12345678;
    PREADY = 1'b0;
    @(posedge PCLK); #1 cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    check_eq("prerst_access", 64'({PSEL, PENABLE}), 64'(2'b11));
    #2 PRESETn = 1'b0;
    #1;
    check_eq("midrst_bus", 64'({PSEL, PENABLE, PWRITE}), 64'(0));
    check_eq("midrst_paddr", 64'(PADDR), 64'(0));
    check_eq("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check_eq("postrst_psel", 64'(PSEL), 64'(0));
      check_eq("postrst_rsp_valid", 64'(rsp_valid), 64'(0));
    end
    @(posedge PCLK); #1;
    run_xfer(mk(1'b0, 32'h20, 32'h0, 0, 1'b0, 0), 1'b0, c0);
    run_xfer(mk(1'b1, 32'h20, 32'hA5A5A5A5, 2, 1'b0, 0), 1'b0, c0);
    run_xfer(mk(1'b0, 32'h20, 32'h0, 1, 1'b0, 0), 1'b0, c0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      cmd_t r;
      r.wr    = 1'($urandom_range(0, 1));
      r.addr  = 32'($urandom_range(0, 15)) << 2;
      r.wdata = $urandom;
      r.waits = int'($urandom_range(0, 5));
      r.serr  = ($urandom_range(0, 5) == 0);
      r.stall = int'($urandom_range(0, 3));
      rq.push_back(r);
    end
    for (int i = 0; i < 40; i++) begin
      run_xfer(rq[i], (i < 39) && ($urandom_range(0, 1) == 1), rq[(i < 39) ? i + 1 : i]);
    end
    for (int i = 0; i < 16; i++) check_eq("mem_final", 64'(cmp_mem[i]), 64'(mdl_mem[i]));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
